// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounces mode/inc/alarm buttons and edits BCD start time and alarm time.
// Latency: raw button edge to register update is DEB_CYCLES+4 clk edges (2 sync, DEB_CYCLES debounce, 1 pulse, 1 update).
// Backpressure: none; buttons are free-running levels and every output is a registered level or one-cycle strobe.
// Optional feature macro: TIME_SET_REPEAT_EN (auto-repeat increment while inc is held in an edit state).
module time_set_ctrl #(
   parameter int DEB_CYCLES    = 1_000_000,
   parameter int REPEAT_CYCLES = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_alm,
   output logic [3:0] hourdec_init,
   output logic [3:0] hourone_init,
   output logic [3:0] mindec_init,
   output logic [3:0] minone_init,
   output logic       time_load,
   output logic [3:0] hourdec_bud,
   output logic [3:0] hourone_bud,
   output logic [3:0] mindec_bud,
   output logic [3:0] minone_bud,
   output logic       bud_en,
   output logic [2:0] edit_state
);

   // Counter holds 0..DEB_CYCLES-1; the flip happens on the edge that would reach DEB_CYCLES.
   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   // Both periods must be at least one cycle for the counters to make sense.
   if (DEB_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
      $error("time_set_ctrl: DEB_CYCLES and REPEAT_CYCLES must be >= 1");
   end

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      SET_HOUR     = 3'd1,
      SET_MIN      = 3'd2,
      SET_ALM_HOUR = 3'd3,
      SET_ALM_MIN  = 3'd4
   } state_t;

   // Button index: 0 = mode, 1 = inc, 2 = alarm.
   logic [2:0]         btn_raw;
   logic [2:0]         sync1_q, sync1_d;
   logic [2:0]         sync2_q, sync2_d;
   logic [2:0]         deb_q, deb_d;
   logic [2:0]         deb_dly_q, deb_dly_d;
   logic [2:0]         press_q, press_d;
   logic [2:0][DW-1:0] cnt_q, cnt_d;

   state_t     state_q, state_d;
   logic       time_load_q, time_load_d;
   logic [3:0] hourdec_init_q, hourdec_init_d;
   logic [3:0] hourone_init_q, hourone_init_d;
   logic [3:0] mindec_init_q, mindec_init_d;
   logic [3:0] minone_init_q, minone_init_d;
   logic [3:0] hourdec_bud_q, hourdec_bud_d;
   logic [3:0] hourone_bud_q, hourone_bud_d;
   logic [3:0] mindec_bud_q, mindec_bud_d;
   logic [3:0] minone_bud_q, minone_bud_d;
   logic       bud_en_q, bud_en_d;

   logic mode_p, inc_p, alm_p;
   logic in_edit;
   logic inc_act;
   logic inc_step;
   logic rpt_fire;

   // Hour step within 00..23; anything out of range folds back to 00.
   function automatic logic [7:0] hour_inc(input logic [3:0] dec, input logic [3:0] one);
      logic [7:0] r;
      if ((dec >= 4'd2 && one >= 4'd3) || dec > 4'd2) begin
         r = 8'h00;
      end else if (one >= 4'd9) begin
         r = {dec + 4'd1, 4'd0};
      end else begin
         r = {dec, one + 4'd1};
      end
      return r;
   endfunction

   // Minute step within 00..59; never carries into the hour.
   function automatic logic [7:0] min_inc(input logic [3:0] dec, input logic [3:0] one);
      logic [7:0] r;
      if ((dec >= 4'd5 && one >= 4'd9) || dec > 4'd5) begin
         r = 8'h00;
      end else if (one >= 4'd9) begin
         r = {dec + 4'd1, 4'd0};
      end else begin
         r = {dec, one + 4'd1};
      end
      return r;
   endfunction

   assign btn_raw = {btn_alm, btn_inc, btn_mode};

   // Per-button synchronizer, debounce counter and rising-edge press pulse.
   always_comb begin
      sync1_d   = btn_raw;
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      deb_dly_d = deb_q;
      press_d   = deb_q & ~deb_dly_q;
      cnt_d     = '0;
      for (int i = 0; i < 3; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DEB_LAST) begin
               deb_d[i] = ~deb_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign mode_p   = press_q[0];
   assign inc_p    = press_q[1];
   assign alm_p    = press_q[2];
   assign in_edit  = (state_q != IDLE);
   // A mode press in the same cycle swallows the increment.
   assign inc_act  = inc_p & ~mode_p & in_edit;
   assign inc_step = inc_act | rpt_fire;

`ifdef TIME_SET_REPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic          rpt_arm_q, rpt_arm_d;

   // Repeat timer: armed by an accepted inc press, disarmed by release, mode press or leaving edit.
   always_comb begin
      rpt_fire  = rpt_arm_q & deb_q[1] & in_edit & ~mode_p & (rpt_cnt_q == RPT_LAST);
      rpt_arm_d = rpt_arm_q;
      rpt_cnt_d = rpt_cnt_q + 1'b1;
      if (mode_p || !deb_q[1] || !in_edit) begin
         rpt_arm_d = 1'b0;
         rpt_cnt_d = '0;
      end else if (inc_act) begin
         rpt_arm_d = 1'b1;
         rpt_cnt_d = '0;
      end else if (!rpt_arm_q || rpt_fire) begin
         rpt_cnt_d = '0;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   // Edit FSM next state, digit increments, alarm toggle and load strobe.
   always_comb begin
      state_d        = state_q;
      time_load_d    = 1'b0;
      hourdec_init_d = hourdec_init_q;
      hourone_init_d = hourone_init_q;
      mindec_init_d  = mindec_init_q;
      minone_init_d  = minone_init_q;
      hourdec_bud_d  = hourdec_bud_q;
      hourone_bud_d  = hourone_bud_q;
      mindec_bud_d   = mindec_bud_q;
      minone_bud_d   = minone_bud_q;
      bud_en_d       = bud_en_q;
      if (mode_p) begin
         case (state_q)
            IDLE:         state_d = SET_HOUR;
            SET_HOUR:     state_d = SET_MIN;
            SET_MIN: begin
               state_d     = SET_ALM_HOUR;
               time_load_d = 1'b1;
            end
            SET_ALM_HOUR: state_d = SET_ALM_MIN;
            default:      state_d = IDLE;
         endcase
      end else begin
         if (inc_step) begin
            case (state_q)
               SET_HOUR:     {hourdec_init_d, hourone_init_d} = hour_inc(hourdec_init_q, hourone_init_q);
               SET_MIN:      {mindec_init_d, minone_init_d}   = min_inc(mindec_init_q, minone_init_q);
               SET_ALM_HOUR: {hourdec_bud_d, hourone_bud_d}   = hour_inc(hourdec_bud_q, hourone_bud_q);
               SET_ALM_MIN:  {mindec_bud_d, minone_bud_d}     = min_inc(mindec_bud_q, minone_bud_q);
               default:      ;
            endcase
         end
         // Alarm toggle only counts in IDLE, so an inc+alm coincidence resolves by state.
         if (alm_p && state_q == IDLE) begin
            bud_en_d = ~bud_en_q;
         end
      end
   end

   // All state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q        <= '0;
         sync2_q        <= '0;
         deb_q          <= '0;
         deb_dly_q      <= '0;
         press_q        <= '0;
         cnt_q          <= '0;
         state_q        <= IDLE;
         time_load_q    <= 1'b0;
         hourdec_init_q <= '0;
         hourone_init_q <= '0;
         mindec_init_q  <= '0;
         minone_init_q  <= '0;
         hourdec_bud_q  <= '0;
         hourone_bud_q  <= '0;
         mindec_bud_q   <= '0;
         minone_bud_q   <= '0;
         bud_en_q       <= 1'b0;
`ifdef TIME_SET_REPEAT_EN
         rpt_cnt_q      <= '0;
         rpt_arm_q      <= 1'b0;
`endif
      end else begin
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         deb_q          <= deb_d;
         deb_dly_q      <= deb_dly_d;
         press_q        <= press_d;
         cnt_q          <= cnt_d;
         state_q        <= state_d;
         time_load_q    <= time_load_d;
         hourdec_init_q <= hourdec_init_d;
         hourone_init_q <= hourone_init_d;
         mindec_init_q  <= mindec_init_d;
         minone_init_q  <= minone_init_d;
         hourdec_bud_q  <= hourdec_bud_d;
         hourone_bud_q  <= hourone_bud_d;
         mindec_bud_q   <= mindec_bud_d;
         minone_bud_q   <= minone_bud_d;
         bud_en_q       <= bud_en_d;
`ifdef TIME_SET_REPEAT_EN
         rpt_cnt_q      <= rpt_cnt_d;
         rpt_arm_q      <= rpt_arm_d;
`endif
      end
   end

   assign hourdec_init = hourdec_init_q;
   assign hourone_init = hourone_init_q;
   assign mindec_init  = mindec_init_q;
   assign minone_init  = minone_init_q;
   assign time_load    = time_load_q;
   assign hourdec_bud  = hourdec_bud_q;
   assign hourone_bud  = hourone_bud_q;
   assign mindec_bud   = mindec_bud_q;
   assign minone_bud   = minone_bud_q;
   assign bud_en       = bud_en_q;
   assign edit_state   = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed scenarios for time_set_ctrl with DEB_CYCLES=4, REPEAT_CYCLES=8.
// Latency: inputs driven and outputs sampled on the falling edge; press effect lands DEB+4 rising edges later.
// Backpressure: none; stimulus is raw button levels only.
module tb_time_set_ctrl;
   localparam int DEB = 4;
   localparam int RPT = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_mode, btn_inc, btn_alm;
   logic [3:0] hourdec_init, hourone_init, mindec_init, minone_init;
   logic       time_load;
   logic [3:0] hourdec_bud, hourone_bud, mindec_bud, minone_bud;
   logic       bud_en;
   logic [2:0] edit_state;

   wire [15:0] init_w = {hourdec_init, hourone_init, mindec_init, minone_init};
   wire [15:0] bud_w  = {hourdec_bud, hourone_bud, mindec_bud, minone_bud};

   int         n_checks = 0;
   int         n_fail   = 0;
   int         tl_count = 0;
   logic [2:0] tl_state = 3'd0;

   time_set_ctrl #(.DEB_CYCLES(DEB), .REPEAT_CYCLES(RPT)) dut (
      .clk(clk), .rst(rst),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_alm(btn_alm),
      .hourdec_init(hourdec_init), .hourone_init(hourone_init),
      .mindec_init(mindec_init), .minone_init(minone_init),
      .time_load(time_load),
      .hourdec_bud(hourdec_bud), .hourone_bud(hourone_bud),
      .mindec_bud(mindec_bud), .minone_bud(minone_bud),
      .bud_en(bud_en), .edit_state(edit_state)
   );

   always #5 clk = ~clk;

   // Count every cycle the load strobe is high and note the state beside it.
   always @(negedge clk) begin
      if (time_load === 1'b1) begin
         tl_count = tl_count + 1;
         tl_state = edit_state;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // which: bit0 mode, bit1 inc, bit2 alm; held 6 cycles then released and settled.
   task automatic press(input logic [2:0] which);
      {btn_alm, btn_inc, btn_mode} = which;
      tick(6);
      {btn_alm, btn_inc, btn_mode} = 3'b000;
      tick(12);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      {btn_alm, btn_inc, btn_mode} = 3'b000;
      tick(3);
      n_checks++; if (init_w !== 16'h0000) begin n_fail++; $display("FAIL reset_init got %h want 0000", init_w); end
      n_checks++; if (bud_w !== 16'h0000) begin n_fail++; $display("FAIL reset_bud got %h want 0000", bud_w); end
      n_checks++; if (bud_en !== 1'b0) begin n_fail++; $display("FAIL reset_bud_en got %b want 0", bud_en); end
      n_checks++; if (time_load !== 1'b0) begin n_fail++; $display("FAIL reset_time_load got %b want 0", time_load); end
      n_checks++; if (edit_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", edit_state); end
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_hour_wrap;
      logic [15:0] exp;
      int h;
      press(3'b001);
      n_checks++; if (edit_state !== 3'd1) begin n_fail++; $display("FAIL hour_enter_state got %0d want 1", edit_state); end
      for (int i = 1; i <= 24; i++) begin
         press(3'b010);
         h = i % 24;
         exp = {4'(h / 10), 4'(h % 10), 8'h00};
         n_checks++; if (init_w !== exp) begin n_fail++; $display("FAIL hour_step_%0d got %h want %h", i, init_w, exp); end
      end
      n_checks++; if (tl_count !== 0) begin n_fail++; $display("FAIL hour_no_load got %0d want 0", tl_count); end
   endtask

   task automatic test_glitch;
      btn_inc = 1'b1; tick(3); btn_inc = 1'b0; tick(15);
      n_checks++; if (init_w !== 16'h0000) begin n_fail++; $display("FAIL glitch_ignored got %h want 0000", init_w); end
      btn_inc = 1'b1;
      tick(DEB + 3);
      n_checks++; if (init_w !== 16'h0000) begin n_fail++; $display("FAIL held_early got %h want 0000", init_w); end
      tick(1);
      n_checks++; if (init_w !== 16'h0100) begin n_fail++; $display("FAIL held_on_time got %h want 0100", init_w); end
      btn_inc = 1'b0;
      tick(14);
      n_checks++; if (init_w !== 16'h0100) begin n_fail++; $display("FAIL held_once got %h want 0100", init_w); end
   endtask

   task automatic test_coincident;
      press(3'b011);
      n_checks++; if (edit_state !== 3'd2) begin n_fail++; $display("FAIL coinc_state got %0d want 2", edit_state); end
      n_checks++; if (init_w !== 16'h0100) begin n_fail++; $display("FAIL coinc_hour got %h want 0100", init_w); end
   endtask

   task automatic test_repeat;
      logic [15:0] exp_mid, exp_end;
`ifdef TIME_SET_REPEAT_EN
      exp_mid = 16'h0103;
      exp_end = 16'h0104;
`else
      exp_mid = 16'h0101;
      exp_end = 16'h0101;
`endif
      btn_inc = 1'b1;
      tick(30);
      n_checks++; if (init_w !== exp_mid) begin n_fail++; $display("FAIL repeat_held got %h want %h", init_w, exp_mid); end
      btn_inc = 1'b0;
      tick(15);
      n_checks++; if (init_w !== exp_end) begin n_fail++; $display("FAIL repeat_released got %h want %h", init_w, exp_end); end
   endtask

   task automatic test_min_wrap;
      int start;
`ifdef TIME_SET_REPEAT_EN
      start = 4;
`else
      start = 1;
`endif
      for (int i = start; i < 58; i++) press(3'b010);
      n_checks++; if (init_w !== 16'h0158) begin n_fail++; $display("FAIL min_58 got %h want 0158", init_w); end
      press(3'b010);
      n_checks++; if (init_w !== 16'h0159) begin n_fail++; $display("FAIL min_59 got %h want 0159", init_w); end
      press(3'b010);
      n_checks++; if (init_w !== 16'h0100) begin n_fail++; $display("FAIL min_wrap got %h want 0100", init_w); end
      n_checks++; if (tl_count !== 0) begin n_fail++; $display("FAIL min_no_load got %0d want 0", tl_count); end
      press(3'b001);
      n_checks++; if (edit_state !== 3'd3) begin n_fail++; $display("FAIL load_state got %0d want 3", edit_state); end
      n_checks++; if (tl_count !== 1) begin n_fail++; $display("FAIL load_width got %0d want 1", tl_count); end
      n_checks++; if (tl_state !== 3'd3) begin n_fail++; $display("FAIL load_with_state got %0d want 3", tl_state); end
   endtask

   task automatic test_alarm;
      press(3'b100);
      n_checks++; if (bud_en !== 1'b0) begin n_fail++; $display("FAIL alm_in_alm_hour got %b want 0", bud_en); end
      press(3'b001);
      n_checks++; if (edit_state !== 3'd4) begin n_fail++; $display("FAIL alm_min_state got %0d want 4", edit_state); end
      press(3'b010);
      press(3'b010);
      n_checks++; if (bud_w !== 16'h0002) begin n_fail++; $display("FAIL alm_min_inc got %h want 0002", bud_w); end
      press(3'b100);
      n_checks++; if (bud_en !== 1'b0) begin n_fail++; $display("FAIL alm_in_alm_min got %b want 0", bud_en); end
      press(3'b001);
      n_checks++; if (edit_state !== 3'd0) begin n_fail++; $display("FAIL back_idle got %0d want 0", edit_state); end
      n_checks++; if (tl_count !== 1) begin n_fail++; $display("FAIL idle_no_load got %0d want 1", tl_count); end
      press(3'b100);
      n_checks++; if (bud_en !== 1'b1) begin n_fail++; $display("FAIL alm_idle_on got %b want 1", bud_en); end
      press(3'b010);
      n_checks++; if ({init_w, bud_w} !== 32'h0100_0002) begin n_fail++; $display("FAIL inc_idle_ignored got %h want 01000002", {init_w, bud_w}); end
      press(3'b110);
      n_checks++; if (bud_en !== 1'b0) begin n_fail++; $display("FAIL alm_inc_idle_en got %b want 0", bud_en); end
      n_checks++; if ({init_w, bud_w} !== 32'h0100_0002) begin n_fail++; $display("FAIL alm_inc_idle_digits got %h want 01000002", {init_w, bud_w}); end
      press(3'b100);
      n_checks++; if (bud_en !== 1'b1) begin n_fail++; $display("FAIL alm_idle_on2 got %b want 1", bud_en); end
   endtask

   task automatic test_reset_mid;
      press(3'b001); press(3'b001); press(3'b001);
      n_checks++; if (edit_state !== 3'd3) begin n_fail++; $display("FAIL rm_state got %0d want 3", edit_state); end
      n_checks++; if (tl_count !== 2) begin n_fail++; $display("FAIL rm_load_count got %0d want 2", tl_count); end
      for (int i = 0; i < 7; i++) press(3'b010);
      n_checks++; if (bud_w !== 16'h0702) begin n_fail++; $display("FAIL rm_alm_hour got %h want 0702", bud_w); end
      btn_inc = 1'b1;
      tick(4);
      rst = 1'b1;
      tick(1);
      n_checks++; if ({init_w, bud_w} !== 32'h0) begin n_fail++; $display("FAIL rm_digits got %h want 00000000", {init_w, bud_w}); end
      n_checks++; if ({bud_en, time_load, edit_state} !== 5'b0) begin n_fail++; $display("FAIL rm_ctrl got %b want 00000", {bud_en, time_load, edit_state}); end
      rst = 1'b0;
      tick(3);
      btn_inc = 1'b0;
      tick(20);
      n_checks++; if ({init_w, bud_w} !== 32'h0) begin n_fail++; $display("FAIL rm_no_late_inc got %h want 00000000", {init_w, bud_w}); end
      n_checks++; if (edit_state !== 3'd0) begin n_fail++; $display("FAIL rm_idle got %0d want 0", edit_state); end
   endtask

   initial begin
      rst = 1'b1;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      btn_alm  = 1'b0;
      test_reset;
      test_hour_wrap;
      test_glitch;
      test_coincident;
      test_repeat;
      test_min_wrap;
      test_alarm;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
